// File: rtl/rr_merge_scheduler.sv
// Round-robin burst-limited merge of NUM_PORTS input FIFOs into one output FIFO.
// Optional saturating forwarded-word counter on stat_words via RR_MERGE_STATS_EN.
module rr_merge_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int BURST_LEN  = 4,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            buffer_empty,
  input  logic                            buffer_out_full,
  output logic [NUM_PORTS-1:0]            read_en,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            wen,
  output logic [PTR_W-1:0]                grant,
  output logic                            busy
`ifdef RR_MERGE_STATS_EN
  ,
  output logic [31:0]                     stat_words
`endif
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;
  localparam logic [7:0] BL      = 8'(BURST_LEN);
  localparam logic [PTR_W:0] NP  = (PTR_W+1)'(NUM_PORTS);

  logic [0:0]            state;
  logic [7:0]            burst_cnt;
  logic                  keep;
  logic                  found;
  logic [PTR_W-1:0]      next_port;
  logic [PTR_W:0]        cand;
  logic [DATA_WIDTH-1:0] din_sel;

  assign din_sel = din[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign busy    = (state == ST_READ) | (|read_en);

  // burst_cnt is only zero right after reset, so the first grant searches from port 0
  assign keep = (burst_cnt != 8'd0) && (burst_cnt < BL) && !buffer_empty[grant];

  always_comb begin
    found     = 1'b0;
    next_port = grant;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, grant} + (PTR_W+1)'(k);
      if (cand >= NP)
        cand = cand - NP;
      if (!found && !buffer_empty[cand[PTR_W-1:0]]) begin
        found     = 1'b1;
        next_port = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      read_en   <= '0;
      dout      <= '0;
      wen       <= 1'b0;
      grant     <= PTR_W'(NUM_PORTS-1);
      burst_cnt <= 8'd0;
    end else if (buffer_out_full) begin
      wen <= 1'b0;
    end else begin
      unique case (state)
        ST_ARB: begin
          wen <= 1'b0;
          if (keep) begin
            read_en <= NUM_PORTS'(1) << grant;
            state   <= ST_READ;
          end else if (found) begin
            grant     <= next_port;
            burst_cnt <= 8'd0;
            read_en   <= NUM_PORTS'(1) << next_port;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          dout      <= din_sel;
          wen       <= 1'b1;
          read_en   <= '0;
          burst_cnt <= (burst_cnt >= BL) ? burst_cnt : burst_cnt + 8'd1;
          state     <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

`ifdef RR_MERGE_STATS_EN
  always_ff @(negedge clk) begin
    if (rst)
      stat_words <= '0;
    else if (wen && stat_words != 32'hFFFF_FFFF)
      stat_words <= stat_words + 32'd1;
  end
`endif

endmodule

// File: doc/rr_merge_scheduler.md
# rr_merge_scheduler

Round-robin, burst-limited merge scheduler that shares one output spike/packet buffer among NUM_PORTS input FIFOs. Used in the router wherever more than three buffers converge, and wherever strict priority would starve low ports. Drives each input FIFO's read enable, captures the read word and writes it to the output FIFO. Follows the same read-then-write two-phase handshake as the existing merge blocks, so it drops into the same FIFO wiring.

## Interface
- DATA_WIDTH, 32, width of one buffered word
- NUM_PORTS, 4, number of input buffers (2..16)
- BURST_LEN, 4, maximum consecutive words granted to one port before rotation (1..255)
- PTR_W, $clog2(NUM_PORTS), width of the grant index (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on negedge clk
- rst  in  1  synchronous, active-high reset
- din  in  NUM_PORTS*DATA_WIDTH  input FIFO data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- buffer_empty  in  NUM_PORTS  per-port input FIFO empty flags
- buffer_out_full  in  1  output FIFO full
- read_en  out  NUM_PORTS  per-port read enable; one-hot or zero
- dout  out  DATA_WIDTH  word to output FIFO
- wen  out  1  output FIFO write enable
- grant  out  PTR_W  port currently owning the output
- busy  out  1  high while a read or write phase is in progress
- stat_words  out  32  words forwarded, saturating (only with RR_MERGE_STATS_EN)

## Operation
- States: ARB, READ.
- ARB: wen<=0. Selects a port:
  - If burst_cnt<BURST_LEN and !buffer_empty[grant], keep grant.
  - Else search from grant+1 upward, wrapping modulo NUM_PORTS, for the first non-empty port. Set grant to it and clear burst_cnt.
  - If a port is found, read_en[grant]<=1 and go to READ. If none is found, stay in ARB; grant and burst_cnt hold.
- READ: dout<=din[grant], wen<=1, read_en<=0, burst_cnt<=burst_cnt+1 (saturating at BURST_LEN), return to ARB.
- buffer_out_full high at a negedge: all state, read_en, dout and burst_cnt hold; wen<=0. The pending word is written on the first non-full edge.
- burst_cnt width is 8 bits. The comparison is unsigned.
- busy = (state==READ) | (|read_en).
- Reset values: read_en=0, dout=0, wen=0, grant=NUM_PORTS-1 (first search starts at port 0), burst_cnt=0, state=ARB, stat_words=0.
- Reset mid-READ: read_en drops and the captured word is discarded. Upstream must reset its FIFOs together with this block.

## Timing
- Throughput: one word per two clk cycles, the same as the existing merges.
- Latency: port goes non-empty before negedge N → read_en at N → dout/wen at N+1 → next read_en earliest at N+2.
- read_en is high for exactly one cycle per word, except when it is held during buffer_out_full.
- wen is high for exactly one cycle per word. wen never coincides with asserted read_en.
- Simultaneous requests: with burst exhausted, the lowest index after grant wins, with wrap-around.
- If the granted port empties mid-burst, the scheduler rotates immediately, with no idle cycle.

## Configuration
- RR_MERGE_STATS_EN defined: the stat_words port exists. It increments on every wen=1 edge, saturates at 32'hFFFF_FFFF, and clears on rst.
- RR_MERGE_STATS_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset then idle: all buffer_empty=1 for 10 cycles → read_en=0, wen=0, grant=3, busy=0 throughout.
- Single port: port 2 holds 3 words A,B,C, others empty → read_en=4'b0100 on alternating edges; dout A,B,C with wen pulses 2 cycles apart; grant=2.
- Fairness: all 4 ports hold 10 words, BURST_LEN=4 → output order is 4×p0, 4×p1, 4×p2, 4×p3, then 4×p0; no port waits more than 24 cycles.
- Backpressure: buffer_out_full held for 5 cycles during a READ → wen=0 for those cycles, dout stable, and the same word is written exactly once after release; no duplicate and no loss.
- Wrap/early rotate: grant=3 with 1 word left, port 0 non-empty → after that word, grant=0 with burst_cnt=0.
- Stats (macro on): forward 100 words → stat_words=100; rst → 0.
